// File: rtl/hash_cmd_master.sv
// rtl/hash_cmd_master.sv - host-side command issuer and response pairer for the hash-table stream wrapper
//
// hash_cmd_tag_fifo: small in-order queue of {op, key} tags for commands awaiting a response.
//   clk, resetn         : clock, synchronous active-low reset (empties the queue)
//   push, push_data     : enqueue a tag (caller guarantees not full)
//   pop, pop_data       : dequeue the head tag; pop_data always shows the head
//   count               : number of queued tags
//
// hash_cmd_master: packs host read/write/delete requests into {op, key, data} command words,
// remembers each issued command in the tag queue, pairs every response with its tag and
// presents a decoded result. Flags illegal ops, unexpected responses and response timeouts.
//   clk, reset                      : clock, synchronous active-low reset
//   req_valid_i/req_ready_o         : host request handshake; req_op_i, req_key_i, req_data_i
//   cmd_valid_o/cmd_ready_i         : command word handshake; cmd_data_o = {op, key, data}
//   rsp_valid_i/rsp_ready_o         : response handshake; rsp_data_i = {flags[3:0], 28'(data)}
//   res_valid_o/res_ready_i         : host result handshake; res_op_o, res_key_o, res_data_o, res_flags_o
//   inflight_o                      : commands issued but not yet answered
//   err_illegal_op_o, err_unexpected_rsp_o, err_timeout_o : sticky error flags

module hash_cmd_tag_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: an empty queue never exposes stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module hash_cmd_master #(
    parameter int KEY_WIDTH       = 15,
    parameter int DATA_WIDTH      = 15,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [1:0]                           req_op_i,
    input  logic [KEY_WIDTH-1:0]                 req_key_i,
    input  logic [DATA_WIDTH-1:0]                req_data_i,

    output logic                                 cmd_valid_o,
    input  logic                                 cmd_ready_i,
    output logic [2+KEY_WIDTH+DATA_WIDTH-1:0]    cmd_data_o,

    input  logic                                 rsp_valid_i,
    output logic                                 rsp_ready_o,
    input  logic [31:0]                          rsp_data_i,

    output logic                                 res_valid_o,
    input  logic                                 res_ready_i,
    output logic [1:0]                           res_op_o,
    output logic [KEY_WIDTH-1:0]                 res_key_o,
    output logic [DATA_WIDTH-1:0]                res_data_o,
    output logic [3:0]                           res_flags_o,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] inflight_o,
    output logic                                 err_illegal_op_o,
    output logic                                 err_unexpected_rsp_o,
    output logic                                 err_timeout_o
);
    localparam int TAG_W = 2 + KEY_WIDTH;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;

    logic                  req_fire;
    logic                  rsp_fire;
    logic                  tag_push;
    logic                  tag_pop;
    logic [TAG_W-1:0]      tag_head;
    logic [1:0]            tag_op;
    logic [KEY_WIDTH-1:0]  tag_key;
    logic [DATA_WIDTH-1:0] cmd_payload;
    logic [TO_W-1:0]       to_cnt;
    logic [TO_W-1:0]       to_cnt_next;

    // Response bits between the data field and the flags carry nothing for us.
    logic unused_rsp_bits;
    assign unused_rsp_bits = ^rsp_data_i[27:DATA_WIDTH];

    // A full queue blocks requests even if a tag retires this cycle.
    assign req_ready_o = (!cmd_valid_o || cmd_ready_i) && (inflight_o < MAX_CNT);
    assign rsp_ready_o = !res_valid_o || res_ready_i;

    assign req_fire = req_valid_i && req_ready_o;
    assign rsp_fire = rsp_valid_i && rsp_ready_o;

    // Illegal ops complete the handshake but never reach the wrapper.
    assign tag_push = req_fire && (req_op_i != OP_ILLEGAL);
    // Only a tag already queued before this edge can be retired.
    assign tag_pop  = rsp_fire && (inflight_o != '0);

    assign cmd_payload = (req_op_i == OP_WRITE) ? req_data_i : '0;
    assign {tag_op, tag_key} = tag_head;

    hash_cmd_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (reset),
        .push      (tag_push),
        .push_data ({req_op_i, req_key_i}),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .count     (inflight_o)
    );

    // Command output register: holds until accepted, reload wins over clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_valid_o <= 1'b0;
            cmd_data_o  <= '0;
        end else if (tag_push) begin
            cmd_valid_o <= 1'b1;
            cmd_data_o  <= {req_op_i, req_key_i, cmd_payload};
        end else if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            cmd_data_o  <= '0;
        end
    end

    // Result output register: loads on a paired response, drops once the host takes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_valid_o <= 1'b0;
            res_op_o    <= '0;
            res_key_o   <= '0;
            res_data_o  <= '0;
            res_flags_o <= '0;
        end else if (tag_pop) begin
            res_valid_o <= 1'b1;
            res_op_o    <= tag_op;
            res_key_o   <= tag_key;
            res_data_o  <= (tag_op == OP_READ) ? rsp_data_i[DATA_WIDTH-1:0] : '0;
            res_flags_o <= rsp_data_i[31:28];
        end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
        end
    end

    // Timeout counter measures how long the oldest outstanding command has gone unanswered;
    // any response restarts it, an idle interface holds it at zero.
    always_comb begin
        to_cnt_next = to_cnt;
        if (rsp_fire || (inflight_o == '0)) begin
            to_cnt_next = '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt_next = to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_next;
        end
    end

    // Sticky error flags; tags are kept after a timeout so a late response still pairs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_illegal_op_o     <= 1'b0;
            err_unexpected_rsp_o <= 1'b0;
            err_timeout_o        <= 1'b0;
        end else begin
            if (req_fire && (req_op_i == OP_ILLEGAL)) begin
                err_illegal_op_o <= 1'b1;
            end
            if (rsp_fire && (inflight_o == '0)) begin
                err_unexpected_rsp_o <= 1'b1;
            end
            if (to_cnt_next == TO_MAX) begin
                err_timeout_o <= 1'b1;
            end
        end
    end
endmodule
